// File: rtl/key_event_encoder_if.sv
// Key event handshake: producer drives valid/code, consumer drives ready.
interface key_event_encoder_if;
  logic       key_valid;
  logic       key_ready;
  logic [4:0] key_code;

  modport master (
    output key_valid,
    output key_code,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output key_ready
  );
endinterface

// File: rtl/key_event_encoder.sv
// Debounced 18-button key encoder feeding a 4-deep event FIFO.
// Optional auto-repeat of held buttons is enabled by defining KEY_REPEAT_EN.
module key_event_encoder #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned REP_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 swp,
  input  logic [7:0]                 swd,
  key_event_encoder_if.master        key,
  output logic [2:0]                 key_cnt,
  output logic                       ovf,
  output logic                       multi
);

  localparam int unsigned NumBtn  = 18;
  localparam logic [7:0]  DebLast = 8'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || REP_CYCLES < 1) begin : g_param_check
    $error("key_event_encoder: parameter out of range");
  end

  // Digits occupy the low bits so a lowest-index-first scan gives digit priority.
  logic [NumBtn-1:0] raw;
  assign raw = {swd, swp};

  logic [NumBtn-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic [7:0]        cnt_q [NumBtn];
  logic [7:0]        cnt_d [NumBtn];
  logic [NumBtn-1:0] rise, events;

  logic [4:0] mem_q [4];
  logic [4:0] mem_d [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic       ovf_q, ovf_d, multi_q, multi_d;
  logic       push, pop, full, accept;
  logic [4:0] push_code;

  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepW    = $clog2(REP_CYCLES + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REP_CYCLES - 1);

  logic [RepW-1:0]   rep_q [NumBtn];
  logic [RepW-1:0]   rep_d [NumBtn];
  logic [NumBtn-1:0] rep_fire;

  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      rep_fire[i] = deb_q[i] & deb_prev_q[i] & (rep_q[i] == RepLast);
      if (!deb_q[i] || rise[i] || rep_fire[i]) begin
        rep_d[i] = '0;
      end else begin
        rep_d[i] = rep_q[i] + RepW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q <= '{default: '0};
    end else begin
      rep_q <= rep_d;
    end
  end

  assign events = rise | rep_fire;
`else
  assign events = rise;
`endif

  always_comb begin
    push_code = '0;
    // Descending scan: the last hit, i.e. the lowest index, wins.
    for (int i = NumBtn - 1; i >= 0; i--) begin
      if (events[i]) begin
        push_code = (i < 10) ? 5'(i) : 5'(i + 6);
      end
    end
  end

  assign push    = |events;
  assign multi_d = |(events & (events - NumBtn'(1)));

  assign key.key_valid = (fifo_cnt_q != 3'd0);
  assign key.key_code  = key.key_valid ? mem_q[rd_q] : 5'h00;
  assign key_cnt       = fifo_cnt_q;
  assign ovf           = ovf_q;
  assign multi         = multi_q;

  assign pop    = key.key_valid & key.key_ready;
  assign full   = (fifo_cnt_q == 3'd4);
  assign accept = push & (~full | pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (accept) begin
      mem_d[wr_q] = push_code;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) begin
      rd_d = rd_q + 2'd1;
    end
    fifo_cnt_d = fifo_cnt_q + {2'b00, accept} - {2'b00, pop};
    ovf_d      = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '{default: '0};
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
      ovf_q      <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovf_q      <= ovf_d;
      multi_q    <= multi_d;
    end
  end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4: consecutive stable cycles needed to accept a level change on a button (range 1..255).
REQ-002 The block SHALL have parameter REP_CYCLES, default 64: auto-repeat period in cycles, used only under REQ-024.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port swp, input, 10 bits: digit buttons; bit i is digit i; raw and asynchronous.
REQ-006 The block SHALL have port swd, input, 8 bits: function buttons; bit j is swd(j+1), where swd3 = sub and swd8 = equ; raw and asynchronous.
REQ-007 The block SHALL have port key_ready, input, 1 bit: the consumer accepts the head event.
REQ-008 The block SHALL have port key_valid, output, 1 bit: the head event is available.
REQ-009 The block SHALL have port key_code, output, 5 bits: the head event code.
REQ-010 The block SHALL have port key_cnt, output, 3 bits: FIFO occupancy, 0..4.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky flag; an event was dropped because the FIFO was full.
REQ-012 The block SHALL have port multi, output, 1 bit: one-cycle pulse; simultaneous press events occurred and lower-priority ones were discarded.

Function
REQ-013 The block SHALL pass each of the 18 raw inputs through a 2-flop synchronizer.
REQ-014 For each button, the debounced level SHALL toggle only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any return to agreement SHALL clear that button's counter.
REQ-015 A press event SHALL be a debounced 0->1 transition; a 1->0 transition SHALL produce no event.
REQ-016 The block SHALL encode events as follows: digit i gives code i (5'h00..5'h09); swd(j+1) gives 5'h10+j (5'h10..5'h17); all other codes are unused.
REQ-017 When several press events occur in the same cycle, the block SHALL enqueue only the highest-priority one (digits before functions, then lower index first) and SHALL pulse multi for one cycle.
REQ-018 The FIFO SHALL be 4 deep and first-in first-out; key_valid SHALL be 1 exactly when key_cnt != 0; key_code SHALL equal the head entry while key_valid = 1 and 5'h00 otherwise.
REQ-019 The block SHALL pop the head on a cycle where key_valid and key_ready are both 1; key_valid and key_code SHALL stay stable until the pop.
REQ-020 Latency: with an empty FIFO, key_valid SHALL rise exactly DEB_CYCLES+3 clk edges after the first edge that samples the raw input high.
REQ-021 If the FIFO is full, a push without a same-cycle pop SHALL be dropped and SHALL set ovf; a push with a same-cycle pop SHALL be accepted and key_cnt SHALL stay at 4.
REQ-022 If the FIFO is empty, a push SHALL never be forwarded combinationally; key_valid SHALL rise on the following cycle.
REQ-023 ovf SHALL be cleared only by reset.

Configuration
REQ-024 With KEY_REPEAT_EN defined, a button whose debounced level stays 1 SHALL re-emit its code every REP_CYCLES cycles after the press event, under the same priority, FIFO and ovf rules; without it, each press SHALL yield exactly one event and REP_CYCLES SHALL be unused.

Reset
REQ-025 While rst = 0, all of the following SHALL be cleared immediately: synchronizers, debounced levels, counters, FIFO pointers, key_cnt = 0, key_valid = 0, key_code = 5'h00, ovf = 0, multi = 0.
REQ-026 A button held high when reset is released SHALL produce one event after debounce, because the debounced level restarts at 0.
REQ-027 Reset asserted mid-debounce or with a non-empty FIFO SHALL discard all pending events.

Verification
REQ-028 Scenario: DEB_CYCLES=4, key_ready=1; press swp[2] for 10 cycles, release, then press swp[3] -> two key_valid pulses, codes 5'h02 then 5'h03, the first at the 7th edge after the press.
REQ-029 Scenario: swp[5] held for 3 cycles, then low (a glitch) -> no event, key_cnt stays 0.
REQ-030 Scenario: key_ready=0; enter sequence 2,3,sub,minus,4 -> key_cnt=4 holding 5'h02,5'h03,5'h12,5'h10; ovf=1; then raise key_ready -> the four codes drain in order and key_cnt reaches 0.
REQ-031 Scenario: swp[7] and swd[7] rise in the same cycle -> only 5'h07 is enqueued and multi pulses once.
REQ-032 Scenario: FIFO full with key_ready=1 and a new press arriving on the pop cycle -> key_cnt stays 4 and ovf stays 0.
REQ-033 Scenario: rst pulsed low with key_cnt=3 -> all outputs are 0 immediately and no stale code appears after release.
